branch_target_buffer: RTL and testbench

- Direct-mapped branch target buffer that stores one 2-bit direction state per entry, plus a tag and a target.
- Fetch side: combinational lookup on the fetch PC returns hit, predicted direction and predicted target.
- Execute side: registered update on every resolved branch advances that entry's state using the team's 2-bit branch state machine.
- Also keeps saturating counts of resolved branches and mispredictions for performance readout.

---
 rtl/branch_target_buffer_pkg.sv | 29 ++
 rtl/btb_entry_array.sv | 69 ++++++
 rtl/branch_target_buffer.sv | 111 +++++++++++
 tb/tb_branch_target_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer and the standalone branch state machine.
// Both use next_state() below, so they follow one set of direction-state transitions.
package branch_target_buffer_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        ST_0 = 2'b00,
        ST_1 = 2'b01,
        ST_2 = 2'b10,
        ST_3 = 2'b11
    } dir_state_t;

    localparam dir_state_t ALLOC_STATE = ST_1;

    function automatic dir_state_t next_state(input dir_state_t cur, input logic taken);
        dir_state_t nxt;
        nxt = ST_0;
        case (cur)
            ST_0:    nxt = taken ? ST_1 : ST_0;
            ST_1:    nxt = taken ? ST_2 : ST_0;
            ST_2:    nxt = taken ? ST_2 : ST_3;
            ST_3:    nxt = taken ? ST_2 : ST_0;
            default: nxt = ST_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_entry_array.sv
// Entry storage for the branch target buffer: valid, tag, target and direction state per index.
// Reads are combinational; writes take effect on the clock edge. Reset clears only valid and state.
module btb_entry_array
    import branch_target_buffer_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_W      = 27,
    parameter int TGT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch-side read
    input  logic [INDEX_BITS-1:0] i_lk_idx,
    output logic                  o_lk_valid,
    output logic [TAG_W-1:0]      o_lk_tag,
    output logic [TGT_W-1:0]      o_lk_target,
    output dir_state_t            o_lk_state,
    // update-side read
    input  logic [INDEX_BITS-1:0] i_up_idx,
    output logic                  o_up_valid,
    output logic [TAG_W-1:0]      o_up_tag,
    output logic [TGT_W-1:0]      o_up_target,
    output dir_state_t            o_up_state,
    // write
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [TGT_W-1:0]      i_wr_target,
    input  dir_state_t            i_wr_state
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic             r_valid  [DEPTH];
    dir_state_t       r_state  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [TGT_W-1:0] r_target [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_state[i] <= ST_0;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_state[i_wr_idx] <= i_wr_state;
        end
    end

    // Tag/target need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst && i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    assign o_lk_valid  = r_valid[i_lk_idx];
    assign o_lk_tag    = r_tag[i_lk_idx];
    assign o_lk_target = r_target[i_lk_idx];
    assign o_lk_state  = r_state[i_lk_idx];

    assign o_up_valid  = r_valid[i_up_idx];
    assign o_up_tag    = r_tag[i_up_idx];
    assign o_up_target = r_target[i_up_idx];
    assign o_up_state  = r_state[i_up_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency fetch lookup, registered update with 2-bit direction state.
// upd_mispredict follows its update by one cycle; no backpressure, one update accepted per cycle.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int PC_W       = branch_target_buffer_pkg::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic            upd_mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int TAG_W = PC_W - INDEX_BITS - 2;

    logic [INDEX_BITS-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0]      w_lk_tag, w_up_tag;
    logic                  w_lk_valid, w_up_valid;
    logic [TAG_W-1:0]      w_lk_stag, w_up_stag;
    logic [PC_W-1:0]       w_lk_starget, w_up_starget;
    dir_state_t            w_lk_state, w_up_state;

    logic                  w_lk_hit, w_up_hit, w_up_pred_taken, w_mispredict;
    logic                  w_wr_en;
    logic [PC_W-1:0]       w_wr_target;
    dir_state_t            w_wr_state;
    logic                  w_unused;

    logic                  r_upd_mispredict;
    logic [31:0]           r_stat_branches, r_stat_mispredicts;

    assign w_lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign w_lk_tag = lookup_pc[PC_W-1:INDEX_BITS+2];
    assign w_up_idx = upd_pc[INDEX_BITS+1:2];
    assign w_up_tag = upd_pc[PC_W-1:INDEX_BITS+2];
    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    btb_entry_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .TGT_W      (PC_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_lk_idx    (w_lk_idx),
        .o_lk_valid  (w_lk_valid),
        .o_lk_tag    (w_lk_stag),
        .o_lk_target (w_lk_starget),
        .o_lk_state  (w_lk_state),
        .i_up_idx    (w_up_idx),
        .o_up_valid  (w_up_valid),
        .o_up_tag    (w_up_stag),
        .o_up_target (w_up_starget),
        .o_up_state  (w_up_state),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_up_idx),
        .i_wr_tag    (w_up_tag),
        .i_wr_target (w_wr_target),
        .i_wr_state  (w_wr_state)
    );

    assign w_lk_hit    = w_lk_valid && (w_lk_stag == w_lk_tag);
    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_hit && w_lk_state[1];
    assign pred_target = w_lk_hit ? w_lk_starget : lookup_pc + PC_W'(4);

    assign w_up_hit        = w_up_valid && (w_up_stag == w_up_tag);
    assign w_up_pred_taken = w_up_hit && w_up_state[1];
    assign w_mispredict    = (w_up_pred_taken != upd_taken) ||
                             (w_up_pred_taken && upd_taken && (w_up_starget != upd_target));

    // A not-taken miss leaves the table alone; everything else rewrites the whole entry.
    always_comb begin
        w_wr_en     = upd_valid && (w_up_hit || upd_taken);
        w_wr_target = upd_target;
        w_wr_state  = ALLOC_STATE;
        if (w_up_hit) begin
            w_wr_state  = next_state(w_up_state, upd_taken);
            w_wr_target = upd_taken ? upd_target : w_up_starget;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_mispredict   <= 1'b0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            r_upd_mispredict <= upd_valid && w_mispredict;
            if (upd_valid && (r_stat_branches != 32'hFFFF_FFFF))
                r_stat_branches <= r_stat_branches + 32'd1;
            if (upd_valid && w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign upd_mispredict   = r_upd_mispredict;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus random traffic, checked against a table model.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_branches, stat_mispredicts;

    int total = 0;
    int bad   = 0;

    // model: direction strength 0..3, taken predicted when strength >= 2
    bit          m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_st    [8];
    logic [31:0] m_br, m_mp;
    int          st_on_taken [4] = '{1, 2, 2, 2};
    int          st_on_nt    [4] = '{0, 0, 3, 0};

    branch_target_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[pc[4:2]] && (m_tag[pc[4:2]] == pc[31:5]);
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_st[pc[4:2]] >= 2);
    endfunction

    // One cycle: present inputs, check lookup before the edge, advance model, check registered outputs.
    task automatic step(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg, input logic [31:0] lpc);
        bit           mp, h;
        int           ix;
        logic [31:0]  exp_tgt;
        rst = r; upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg; lookup_pc = lpc;
        #1;
        exp_tgt = m_hit(lpc) ? m_tgt[lpc[4:2]] : lpc + 32'd4;
        check("pred_hit",    {31'd0, pred_hit},   {31'd0, m_hit(lpc)});
        check("pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred_taken(lpc)});
        check("pred_target", pred_target, exp_tgt);
        ix = int'(pc[4:2]);
        h  = m_hit(pc);
        mp = (m_pred_taken(pc) != tk) || (m_pred_taken(pc) && tk && m_tgt[ix] != tg);
        @(posedge clk);
        if (r) begin
            foreach (m_valid[i]) begin m_valid[i] = 0; m_st[i] = 0; end
            m_br = 0; m_mp = 0; mp = 0;
        end else if (v) begin
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (mp && m_mp != 32'hFFFF_FFFF) m_mp++;
            if (h) begin
                m_st[ix] = tk ? st_on_taken[m_st[ix]] : st_on_nt[m_st[ix]];
                if (tk) m_tgt[ix] = tg;
            end else if (tk) begin
                m_valid[ix] = 1; m_tag[ix] = pc[31:5]; m_tgt[ix] = tg; m_st[ix] = 1;
            end
        end
        #1;
        check("upd_mispredict",   {31'd0, upd_mispredict}, {31'd0, (!r && v && mp)});
        check("stat_branches",    stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mp);
    endtask

    initial begin
        logic [31:0] pc, tg;
        foreach (m_valid[i]) begin m_valid[i] = 0; m_st[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; end
        m_br = 0; m_mp = 0;
        rst = 1; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; lookup_pc = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 32'h100);
        step(0, 0, 0, 0, 0, 32'h100);
        check("reset_target", pred_target, 32'h104);
        check("reset_hit",    {31'd0, pred_hit}, 32'd0);

        // allocate, then strengthen to taken
        step(0, 1, 32'h100, 1, 32'h200, 32'h100);
        check("alloc_mispredict", {31'd0, upd_mispredict}, 32'd1);
        step(0, 1, 32'h100, 1, 32'h200, 32'h100);
        check("alloc_lookup_tgt", pred_target, 32'h200);
        step(0, 1, 32'h100, 1, 32'h200, 32'h100);
        check("strong_no_mp", {31'd0, upd_mispredict}, 32'd0);
        step(0, 1, 32'h100, 0, 32'h0,   32'h100);
        step(0, 0, 0, 0, 0, 32'h100);
        check("weak_still_taken", {31'd0, pred_taken}, 32'd1);
        step(0, 1, 32'h100, 1, 32'h200, 32'h100);
        step(0, 1, 32'h100, 0, 32'h0,   32'h100);
        step(0, 1, 32'h100, 0, 32'h0,   32'h100);
        step(0, 1, 32'h100, 1, 32'h240, 32'h100);

        // alias: same index, different tag replaces the occupant
        step(0, 1, 32'h120, 1, 32'h300, 32'h100);
        step(0, 0, 0, 0, 0, 32'h100);
        check("alias_old_miss", {31'd0, pred_hit}, 32'd0);
        step(0, 0, 0, 0, 0, 32'h120);
        check("alias_new_tgt", pred_target, 32'h300);

        // reset with a simultaneous taken update discards it
        step(1, 1, 32'h140, 1, 32'h500, 32'h140);
        step(0, 0, 0, 0, 0, 32'h140);
        check("rst_upd_hit", {31'd0, pred_hit}, 32'd0);

        // random traffic over a few tags per index to exercise hits, aliasing and target changes
        for (int n = 0; n < 400; n++) begin
            pc = {25'd0, 3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
            tg = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), pc,
                 bit'($urandom_range(0, 1)), tg,
                 {25'd0, 3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)});
        end

        // saturation of the branch counter
        step(0, 0, 0, 0, 0, 32'h100);
        force dut.r_stat_branches = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.r_stat_branches;
        m_br = 32'hFFFF_FFFE;
        step(0, 1, 32'h100, 0, 0, 32'h100);
        step(0, 1, 32'h100, 0, 0, 32'h100);
        check("sat_hold", stat_branches, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
